if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC, drives the instruction ROM
//  address, and captures the returned word into the IF/ID pipeline register.
//  Honours load-use stalls from the hazard unit and branch redirects resolved in EX.
//  On a taken branch it flushes the wrongly fetched IF/ID word; ID/EX flushing is done by the hazard unit.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded on reset (must be word-aligned)
//  NOP_INST  32'h0000_0000  word inserted into IF/ID on reset and on flush (sll $0,$0,0)
// PORTS
//  Clk           in   1   pipeline clock; all state updates on rising edge
//  Rst           in   1   synchronous, active-high reset
//  Stall         in   1   hold PC and IF/ID this cycle (load-use hazard)
//  BranchTaken   in   1   EX-stage redirect; priority over Stall
//  BranchTarget  in   32  redirect PC from EX; bits [1:0] ignored (forced 2'b00)
//  InstAddr      out  32  current PC, to instruction ROM Addr (ROM is combinational)
//  InstIn        in   32  instruction word from ROM for InstAddr, same cycle
//  IF_ID_Inst    out  32  registered instruction to decode
//  IF_ID_PC4     out  32  registered PC+4 of IF_ID_Inst (branch-target base in ID/EX)
//  IF_ID_Valid   out  1   1 = IF_ID_Inst is a real fetch, 0 = bubble
//  FetchCount    out  32  number of words captured into IF/ID with Valid=1 since reset
// BEHAVIOUR
//  - InstAddr = PC register, combinational; no other combinational path to outputs.
//  - Priority per rising edge: Rst > BranchTaken > Stall > normal advance.
//  - Rst=1: PC<=RESET_PC; IF_ID_Inst<=NOP_INST; IF_ID_PC4<=0; IF_ID_Valid<=0; FetchCount<=0.
//    Applies mid-operation too: all in-flight fetch state discarded, no partial update.
//  - BranchTaken=1: PC<={BranchTarget[31:2],2'b00}; IF_ID_Inst<=NOP_INST; IF_ID_PC4<=0;
//    IF_ID_Valid<=0; FetchCount unchanged. Stall in the same cycle is ignored.
//  - Stall=1 (no branch): PC, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, FetchCount all hold.
//  - Normal: PC<=PC+4; IF_ID_Inst<=InstIn; IF_ID_PC4<=PC+4; IF_ID_Valid<=1; FetchCount<=FetchCount+1.
//  - Latency: word at InstAddr in cycle N appears on IF_ID_Inst after edge N (1 cycle).
//  - Branch penalty as seen by this block: 1 bubble in IF/ID; target word reaches IF/ID
//    on the second edge after BranchTaken is sampled.
//  - Arithmetic: PC+4 and FetchCount are 32-bit modulo; 32'hFFFF_FFFC advances to 32'h0,
//    FetchCount 32'hFFFF_FFFF wraps to 0. No exception on wrap.
//  - ROM aliasing (Addr[9:2] only) is not this block's concern; PC is never truncated here.
//  - No internal FSM beyond the PC/IF-ID registers; stall/flush fully described by the priority above.
// STRUCTURE
//  - Shared package (cpu_pkg): NOP_INST, RESET_PC defaults, 32-bit word width constant.
//  - One sub-module: pc_reg (PC register with reset/load/hold/increment); IF/ID register in top.
//  - Instruction ROM instantiated at the CPU top, not inside this block.
// TESTING (bench pairs block with the sample-program instruction ROM)
//  1 Rst high 2 cycles -> InstAddr=0, IF_ID_Inst=0, IF_ID_PC4=0, IF_ID_Valid=0, FetchCount=0.
//  2 Release reset, 2 free cycles -> IF_ID_Inst=32'h34010005/PC4=4, then 32'h34020005/PC4=8;
//    InstAddr=8; FetchCount=2.
//  3 At InstAddr=8 assert Stall 2 cycles -> InstAddr stays 8, IF_ID_Inst stays 32'h34020005,
//    FetchCount stays 2; release -> IF_ID_Inst=32'h10220002, PC4=12.
//  4 BranchTaken=1, BranchTarget=32'h17, Stall=1 same cycle -> next: InstAddr=32'h14,
//    IF_ID_Inst=0, Valid=0; following edge: IF_ID_Inst=32'h3409000A, PC4=32'h18, Valid=1.
//  5 Force PC via BranchTarget=32'hFFFF_FFFC, one free cycle -> InstAddr=0, IF_ID_PC4=0.
//  6 Rst asserted during a Stall at PC=32'h20 -> next edge all outputs at reset values, InstAddr=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, reset PC, NOP encoding and word-alignment helper.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] CPU_RESET_PC = 32'h0000_0000;
  localparam logic [WORD_W-1:0] CPU_NOP_INST = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [WORD_W-1:0] PC_STEP      = 32'h0000_0004;

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction ROM port and IF/ID outputs.
interface if_stage_if;
  import cpu_pkg::*;

  logic              Stall;
  logic              BranchTaken;
  logic [WORD_W-1:0] BranchTarget;
  logic [WORD_W-1:0] InstAddr;
  logic [WORD_W-1:0] InstIn;
  logic [WORD_W-1:0] IF_ID_Inst;
  logic [WORD_W-1:0] IF_ID_PC4;
  logic              IF_ID_Valid;
  logic [WORD_W-1:0] FetchCount;

  modport master (
    output Stall, BranchTaken, BranchTarget, InstIn,
    input  InstAddr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, FetchCount
  );

  modport slave (
    input  Stall, BranchTaken, BranchTarget, InstIn,
    output InstAddr, IF_ID_Inst, IF_ID_PC4, IF_ID_Valid, FetchCount
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: reset > load (redirect) > hold (stall) > increment by one word.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = CPU_RESET_PC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_hold,
  input  logic [WORD_W-1:0] i_load_val,
  output logic [WORD_W-1:0] o_pc
);

  logic [WORD_W-1:0] r_pc;

  // PC update with fixed priority; the increment wraps modulo 2^32
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= word_align(i_load_val);
    end else if (i_hold) begin
      r_pc <= r_pc;
    end else begin
      r_pc <= r_pc + PC_STEP;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC via pc_reg, IF/ID pipeline register and fetch counter.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = CPU_RESET_PC,
  parameter logic [WORD_W-1:0] NOP_INST = CPU_NOP_INST
) (
  input logic        Clk,
  input logic        Rst,
  if_stage_if.slave  bus
);

  logic [WORD_W-1:0] w_pc;
  logic [WORD_W-1:0] w_pc_plus4;
  logic [WORD_W-1:0] r_inst;
  logic [WORD_W-1:0] r_pc4;
  logic              r_valid;
  logic [WORD_W-1:0] r_fetch_count;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .i_clk      (Clk),
    .i_rst      (Rst),
    .i_load     (bus.BranchTaken),
    .i_hold     (bus.Stall),
    .i_load_val (bus.BranchTarget),
    .o_pc       (w_pc)
  );

  assign w_pc_plus4 = w_pc + PC_STEP;

  // IF/ID register: a redirect squashes the word fetched down the wrong path
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_inst        <= NOP_INST;
      r_pc4         <= 32'h0000_0000;
      r_valid       <= 1'b0;
      r_fetch_count <= 32'h0000_0000;
    end else if (bus.BranchTaken) begin
      r_inst        <= NOP_INST;
      r_pc4         <= 32'h0000_0000;
      r_valid       <= 1'b0;
      r_fetch_count <= r_fetch_count;
    end else if (bus.Stall) begin
      r_inst        <= r_inst;
      r_pc4         <= r_pc4;
      r_valid       <= r_valid;
      r_fetch_count <= r_fetch_count;
    end else begin
      r_inst        <= bus.InstIn;
      r_pc4         <= w_pc_plus4;
      r_valid       <= 1'b1;
      r_fetch_count <= r_fetch_count + 32'h0000_0001;
    end
  end

  assign bus.InstAddr    = w_pc;
  assign bus.IF_ID_Inst  = r_inst;
  assign bus.IF_ID_PC4   = r_pc4;
  assign bus.IF_ID_Valid = r_valid;
  assign bus.FetchCount  = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage paired with a small sample-program instruction ROM.
module tb_if_stage;
  import cpu_pkg::*;

  logic Clk;
  logic Rst;
  int   pass_cnt;
  int   total_cnt;

  if_stage_if bus ();

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0000)
  ) u_dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Combinational sample-program ROM, word-indexed by Addr[9:2]
  function automatic logic [31:0] rom(input logic [31:0] addr);
    case (addr[9:2])
      8'd0:    return 32'h3401_0005;
      8'd1:    return 32'h3402_0005;
      8'd2:    return 32'h1022_0002;
      8'd3:    return 32'h3403_0001;
      8'd4:    return 32'h3404_0002;
      8'd5:    return 32'h3409_000A;
      8'd6:    return 32'h0800_0006;
      8'd8:    return 32'h3405_0007;
      default: return 32'h0000_0000;
    endcase
  endfunction

  always_comb bus.InstIn = rom(bus.InstAddr);

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s got %h expected %h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    tick();
    tick();
    chk("rst_addr",  bus.InstAddr,    32'h0000_0000);
    chk("rst_inst",  bus.IF_ID_Inst,  32'h0000_0000);
    chk("rst_pc4",   bus.IF_ID_PC4,   32'h0000_0000);
    chk("rst_valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    chk("rst_count", bus.FetchCount,  32'd0);
  endtask

  task automatic test_advance();
    Rst = 1'b0;
    tick();
    chk("adv1_inst",  bus.IF_ID_Inst, 32'h3401_0005);
    chk("adv1_pc4",   bus.IF_ID_PC4,  32'h0000_0004);
    chk("adv1_valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
    tick();
    chk("adv2_inst",  bus.IF_ID_Inst, 32'h3402_0005);
    chk("adv2_pc4",   bus.IF_ID_PC4,  32'h0000_0008);
    chk("adv2_addr",  bus.InstAddr,   32'h0000_0008);
    chk("adv2_count", bus.FetchCount, 32'd2);
  endtask

  task automatic test_stall();
    bus.Stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_addr",  bus.InstAddr,   32'h0000_0008);
      chk("stall_inst",  bus.IF_ID_Inst, 32'h3402_0005);
      chk("stall_count", bus.FetchCount, 32'd2);
    end
    bus.Stall = 1'b0;
    tick();
    chk("unstall_inst",  bus.IF_ID_Inst, 32'h1022_0002);
    chk("unstall_pc4",   bus.IF_ID_PC4,  32'h0000_000C);
    chk("unstall_addr",  bus.InstAddr,   32'h0000_000C);
    chk("unstall_count", bus.FetchCount, 32'd3);
  endtask

  task automatic test_branch_over_stall();
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h0000_0017;
    bus.Stall        = 1'b1;
    tick();
    bus.BranchTaken = 1'b0;
    bus.Stall       = 1'b0;
    chk("br_addr",  bus.InstAddr,   32'h0000_0014);
    chk("br_inst",  bus.IF_ID_Inst, 32'h0000_0000);
    chk("br_pc4",   bus.IF_ID_PC4,  32'h0000_0000);
    chk("br_valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    chk("br_count", bus.FetchCount, 32'd3);
    tick();
    chk("tgt_inst",  bus.IF_ID_Inst, 32'h3409_000A);
    chk("tgt_pc4",   bus.IF_ID_PC4,  32'h0000_0018);
    chk("tgt_valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
    chk("tgt_count", bus.FetchCount, 32'd4);
  endtask

  task automatic test_pc_wrap();
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'hFFFF_FFFC;
    tick();
    bus.BranchTaken = 1'b0;
    chk("wrap_top", bus.InstAddr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr",  bus.InstAddr,   32'h0000_0000);
    chk("wrap_pc4",   bus.IF_ID_PC4,  32'h0000_0000);
    chk("wrap_inst",  bus.IF_ID_Inst, 32'h0000_0000);
    chk("wrap_valid", {31'd0, bus.IF_ID_Valid}, 32'd1);
    chk("wrap_count", bus.FetchCount, 32'd5);
  endtask

  task automatic test_reset_during_stall();
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h0000_0020;
    tick();
    bus.BranchTaken = 1'b0;
    tick();
    chk("pre_inst", bus.IF_ID_Inst, 32'h3405_0007);
    chk("pre_pc4",  bus.IF_ID_PC4,  32'h0000_0024);
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h0000_0020;
    tick();
    bus.BranchTaken = 1'b0;
    bus.Stall       = 1'b1;
    tick();
    chk("pre_addr", bus.InstAddr, 32'h0000_0020);
    Rst = 1'b1;
    tick();
    chk("mrst_addr",  bus.InstAddr,   32'h0000_0000);
    chk("mrst_inst",  bus.IF_ID_Inst, 32'h0000_0000);
    chk("mrst_pc4",   bus.IF_ID_PC4,  32'h0000_0000);
    chk("mrst_valid", {31'd0, bus.IF_ID_Valid}, 32'd0);
    chk("mrst_count", bus.FetchCount, 32'd0);
    Rst       = 1'b0;
    bus.Stall = 1'b0;
    tick();
    chk("post_inst",  bus.IF_ID_Inst, 32'h3401_0005);
    chk("post_count", bus.FetchCount, 32'd1);
  endtask

  initial begin
    pass_cnt         = 0;
    total_cnt        = 0;
    Rst              = 1'b1;
    bus.Stall        = 1'b0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = 32'h0000_0000;
    test_reset();
    test_advance();
    test_stall();
    test_branch_over_stall();
    test_pc_wrap();
    test_reset_during_stall();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
